if0_fetch_ctrl: RTL and testbench
=================================

// Module: if0_fetch_ctrl
// PURPOSE
//  Front-end fetch sequencer (IF0). Owns the fetch PC, issues 16-byte-aligned I-cache requests,
//  builds and holds if0_if1_bus plus if0_valid for the IF1 stage, and handles redirects and
//  fetch-address exceptions. Also generates flush_IF for IF1 and a cancel strobe for the I-cache.
//  One fetch block is outstanding at a time.
// PARAMETERS
//  RESET_PC   32'h1C00_0000  PC loaded at reset
//  ECODE_ADEF 6'h08          Ecode driven on a misaligned fetch PC (subEcode 9'h0)
// PORTS
//  clk            in   1   clock
//  rst            in   1   synchronous, active-high reset
//  redirect_valid in   1   branch/exception redirect from the backend
//  redirect_pc    in   32  target PC for the redirect
//  fetch_stall    in   1   suppress new I-cache requests (idle/barrier); in-flight work unaffected
//  req_valid      out  1   I-cache request valid
//  req_addr       out  32  {pc[31:4],4'b0}
//  addr_ok        in   1   I-cache accepted the request this cycle
//  icache_cancel  out  1   discard the outstanding I-cache response
//  if0_valid      out  1   if0_if1_bus holds a fetch block for IF1
//  if0_if1_bus    out  `IF0_TO_IF1_BUS_WD (56)  {in_excp,Ecode[5:0],subEcode[8:0],pc_valid[3:0],pc_is_jump[3:0],fs_pc[31:0]}
//  if1_ready      in   1   IF1 consumed the current block
//  flush_IF       out  1   clear IF1 state (waiting flag, store buffer)
// BEHAVIOUR
//  - Reset: pc=RESET_PC, state=REQ, bus_q=0. While rst=1: req_valid=0, if0_valid=0,
//    icache_cancel=0, flush_IF=0.
//  - States: REQ, RESP, HALT.
//    REQ:  if pc[1:0]!=0, drive no request; load bus_q with in_excp=1, Ecode=ECODE_ADEF,
//          subEcode=0, pc_valid=4'b0001, fs_pc=pc; next state RESP (exception flag set).
//          Otherwise req_valid=~fetch_stall. On req_valid&addr_ok, load bus_q with in_excp=0,
//          pc_valid[i]=(i>=pc[3:2]), pc_is_jump=4'b0 (reserved), fs_pc=pc;
//          set pc<={pc[31:4]+28'd1,4'b0}; next state RESP.
//    RESP: if0_valid=1 and if0_if1_bus=bus_q, held stable. With if1_ready=0, stay in RESP.
//          With if1_ready=1, go to REQ, or to HALT if bus_q.in_excp=1.
//    HALT: no requests and if0_valid=0. Wait for a redirect.
//  - Redirect has the highest priority in every state. In the redirect cycle:
//    flush_IF=1 (combinational), if0_valid forced 0, req_valid forced 0, and pc<=redirect_pc.
//    The next state is REQ. icache_cancel=redirect_valid&(state==RESP).
//    A redirect that coincides with addr_ok does not fire the handshake because req_valid is 0.
//  - Latency: request issues in the REQ cycle, and bus_q is presented in the following cycle.
//    Minimum of 2 cycles per block. A redirect produces a new request one cycle later.
//  - PC arithmetic wraps mod 2^32: 32'hFFFF_FFF0 -> 32'h0000_0000.
//  - fetch_stall only gates req_valid in REQ. It does not affect RESP or HALT.
//  - Reset asserted mid-RESP abandons bus_q. icache_cancel is not asserted.
// STRUCTURE
//  - Shared define.vh: IF0_TO_IF1_BUS_WD=56, ECODE_ADEF, RESET_PC default, bus field offsets.
//  - Single flat module. The state register, pc register and bus_q register are all local.
//    No sub-module.
// TESTING
//  1 Reset release, addr_ok=1, if1_ready=1: req_addr=1C000000 in cycle 1, if0_valid with
//    pc_valid=1111 in cycle 2, req_addr=1C000010 in cycle 3.
//  2 Redirect to 1C000108, then handshake: req_addr=1C000100, pc_valid=1100,
//    fs_pc=1C000108, next req_addr=1C000110.
//  3 if1_ready=0 for 5 cycles in RESP: if0_valid and bus held bit-stable, req_valid=0,
//    pc unchanged.
//  4 Redirect to 1C000002: no req_valid, bus in_excp=1, Ecode=08, pc_valid=0001.
//    After if1_ready, HALT with if0_valid=0 until the next redirect.
//  5 Redirect in RESP: flush_IF=1 and icache_cancel=1 for one cycle, if0_valid=0,
//    new request next cycle. Redirect coincident with addr_ok gives no handshake.
//  6 fetch_stall=1 for 3 cycles in REQ: req_valid=0 throughout, then resumes at the same pc.
//    Separately, pc=FFFFFFF0 wraps to 00000000.

Source files
------------

// File: rtl/if0_fetch_ctrl_pkg.sv
// if0_fetch_ctrl_pkg: shared types and constants for the IF0 fetch sequencer
package if0_fetch_ctrl_pkg;
  localparam int IF0_TO_IF1_BUS_WD = 56;
  localparam logic [31:0] DEF_RESET_PC = 32'h1C00_0000;
  localparam logic [5:0] DEF_ECODE_ADEF = 6'h08;
  typedef enum logic [1:0] {S_REQ, S_RESP, S_HALT} fetch_state_e;
  typedef struct packed {
    logic in_excp;
    logic [5:0] ecode;
    logic [8:0] sub_ecode;
    logic [3:0] pc_valid;
    logic [3:0] pc_is_jump;
    logic [31:0] fs_pc;
  } if0_if1_bus_t;
  function automatic logic [3:0] slot_mask(input logic [1:0] word);
    return 4'b1111 << word;
  endfunction
endpackage

// File: rtl/if0_fetch_ctrl.sv
// if0_fetch_ctrl: IF0 fetch sequencer owning the fetch pc, one block in flight at a time
module if0_fetch_ctrl
  import if0_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [5:0] ECODE_ADEF = DEF_ECODE_ADEF
) (
  input  logic clk,
  input  logic rst,
  input  logic redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic fetch_stall,
  output logic req_valid,
  output logic [31:0] req_addr,
  input  logic addr_ok,
  output logic icache_cancel,
  output logic if0_valid,
  output logic [IF0_TO_IF1_BUS_WD-1:0] if0_if1_bus,
  input  logic if1_ready,
  output logic flush_IF
);
  fetch_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d;
  if0_if1_bus_t bus_q, bus_d;
  logic misaligned, fire;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q <= RESET_PC;
      bus_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      bus_q <= bus_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (redirect_valid) state_d = S_REQ;
    else if (state_q == S_REQ) state_d = (misaligned || fire) ? S_RESP : S_REQ;
    else if (state_q == S_RESP && if1_ready) state_d = bus_q.in_excp ? S_HALT : S_REQ;
  end
  always_comb begin
    pc_d = redirect_valid ? redirect_pc : fire ? {pc_q[31:4] + 28'd1, 4'b0} : pc_q;
    bus_d = bus_q;
    if (!redirect_valid && state_q == S_REQ && misaligned)
      bus_d = '{in_excp: 1'b1, ecode: ECODE_ADEF, sub_ecode: 9'd0, pc_valid: 4'b0001, pc_is_jump: 4'b0, fs_pc: pc_q};
    else if (fire)
      bus_d = '{in_excp: 1'b0, ecode: 6'd0, sub_ecode: 9'd0, pc_valid: slot_mask(pc_q[3:2]), pc_is_jump: 4'b0, fs_pc: pc_q};
  end
  // Redirect masks every handshake, so a coincident addr_ok never loads a stale block.
  always_comb begin
    misaligned = pc_q[1:0] != 2'b00;
    req_valid = !rst && !redirect_valid && state_q == S_REQ && !misaligned && !fetch_stall;
    fire = req_valid && addr_ok;
    req_addr = {pc_q[31:4], 4'b0};
    if0_valid = !rst && !redirect_valid && state_q == S_RESP;
    if0_if1_bus = bus_q;
    flush_IF = !rst && redirect_valid;
    icache_cancel = !rst && redirect_valid && state_q == S_RESP;
  end
endmodule

// File: tb/tb_if0_fetch_ctrl.sv
// tb_if0_fetch_ctrl: directed scenarios plus randomized run against a block-level fetch model
module tb_if0_fetch_ctrl;
  logic clk = 1'b0;
  logic rst, redirect_valid, fetch_stall, addr_ok, if1_ready;
  logic [31:0] redirect_pc;
  logic req_valid, icache_cancel, if0_valid, flush_IF;
  logic [31:0] req_addr;
  logic [55:0] if0_if1_bus;
  int n_cmp = 0, n_err = 0;
  logic [31:0] m_pc;
  logic m_busy, m_halt;
  logic [55:0] m_bus;

  if0_fetch_ctrl dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_stall(fetch_stall), .req_valid(req_valid), .req_addr(req_addr), .addr_ok(addr_ok),
    .icache_cancel(icache_cancel), .if0_valid(if0_valid), .if0_if1_bus(if0_if1_bus),
    .if1_ready(if1_ready), .flush_IF(flush_IF)
  );

  always #5 clk = ~clk;

  // Model: one block is either being presented (busy), or we are halted after an
  // exception block, or we are free to request at m_pc.
  task automatic tick();
    logic [3:0] pv;
    if (rst) begin
      m_pc = 32'h1C00_0000; m_busy = 0; m_halt = 0; m_bus = '0;
    end else if (redirect_valid) begin
      m_pc = redirect_pc; m_busy = 0; m_halt = 0;
    end else if (m_busy) begin
      if (if1_ready) begin m_busy = 0; m_halt = m_bus[55]; end
    end else if (!m_halt) begin
      if (m_pc[1:0] != 2'b00) begin
        m_bus = {1'b1, 6'h08, 9'h0, 4'b0001, 4'b0, m_pc}; m_busy = 1;
      end else if (!fetch_stall && addr_ok) begin
        for (int i = 0; i < 4; i++) pv[i] = (i >= int'(m_pc[3:2]));
        m_bus = {1'b0, 6'h0, 9'h0, pv, 4'b0, m_pc}; m_busy = 1;
        m_pc = (m_pc & ~32'hF) + 32'h10;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1; redirect_valid = 1; redirect_pc = 32'h1234_5670; fetch_stall = 0; addr_ok = 1; if1_ready = 1;
    tick(); tick(); #1;
    n_cmp++; if (req_valid !== 1'b0) begin n_err++; $display("FAIL rst_req_valid: got %b want 0", req_valid); end
    n_cmp++; if (if0_valid !== 1'b0) begin n_err++; $display("FAIL rst_if0_valid: got %b want 0", if0_valid); end
    n_cmp++; if (icache_cancel !== 1'b0) begin n_err++; $display("FAIL rst_cancel: got %b want 0", icache_cancel); end
    n_cmp++; if (flush_IF !== 1'b0) begin n_err++; $display("FAIL rst_flush: got %b want 0", flush_IF); end
    tick();
    rst = 0; redirect_valid = 0; #1;
    n_cmp++; if (if0_if1_bus !== 56'h0) begin n_err++; $display("FAIL rst_bus: got %h want 0", if0_if1_bus); end
    n_cmp++; if (if0_valid !== 1'b0) begin n_err++; $display("FAIL rst_if0_valid_rel: got %b want 0", if0_valid); end
  endtask

  task automatic test_sequential();
    addr_ok = 1; if1_ready = 1; #1;
    n_cmp++; if ({req_valid, req_addr} !== {1'b1, 32'h1C00_0000}) begin n_err++; $display("FAIL seq_req0: got %b/%h want 1/1c000000", req_valid, req_addr); end
    tick();
    n_cmp++; if (if0_valid !== 1'b1 || if0_if1_bus[39:36] !== 4'b1111 || if0_if1_bus[31:0] !== 32'h1C00_0000) begin n_err++; $display("FAIL seq_blk0: got %b/%b/%h want 1/1111/1c000000", if0_valid, if0_if1_bus[39:36], if0_if1_bus[31:0]); end
    n_cmp++; if (req_valid !== 1'b0) begin n_err++; $display("FAIL seq_noreq_resp: got %b want 0", req_valid); end
    tick();
    n_cmp++; if ({req_valid, req_addr} !== {1'b1, 32'h1C00_0010}) begin n_err++; $display("FAIL seq_req1: got %b/%h want 1/1c000010", req_valid, req_addr); end
  endtask

  task automatic test_redirect_partial();
    redirect_valid = 1; redirect_pc = 32'h1C00_0108; #1;
    n_cmp++; if ({flush_IF, req_valid} !== 2'b10) begin n_err++; $display("FAIL rd_cycle: got flush=%b req=%b want 1/0", flush_IF, req_valid); end
    tick();
    redirect_valid = 0; #1;
    n_cmp++; if ({req_valid, req_addr} !== {1'b1, 32'h1C00_0100}) begin n_err++; $display("FAIL rd_req: got %b/%h want 1/1c000100", req_valid, req_addr); end
    if1_ready = 0; tick();
    n_cmp++; if (if0_valid !== 1'b1 || if0_if1_bus[39:36] !== 4'b1100 || if0_if1_bus[31:0] !== 32'h1C00_0108) begin n_err++; $display("FAIL rd_blk: got %b/%b/%h want 1/1100/1c000108", if0_valid, if0_if1_bus[39:36], if0_if1_bus[31:0]); end
    if1_ready = 1; tick();
    n_cmp++; if ({req_valid, req_addr} !== {1'b1, 32'h1C00_0110}) begin n_err++; $display("FAIL rd_next: got %b/%h want 1/1c000110", req_valid, req_addr); end
    tick();
  endtask

  task automatic test_hold();
    if1_ready = 0;
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (if0_valid !== 1'b1 || req_valid !== 1'b0 || if0_if1_bus !== m_bus) begin n_err++; $display("FAIL hold_%0d: got v=%b req=%b bus=%h want 1/0/%h", k, if0_valid, req_valid, if0_if1_bus, m_bus); end
      tick();
    end
    n_cmp++; if (req_addr !== 32'h1C00_0120) begin n_err++; $display("FAIL hold_pc: got %h want 1c000120", req_addr); end
    if1_ready = 1; tick();
    n_cmp++; if ({req_valid, req_addr} !== {1'b1, 32'h1C00_0120}) begin n_err++; $display("FAIL hold_resume: got %b/%h want 1/1c000120", req_valid, req_addr); end
  endtask

  task automatic test_misaligned();
    redirect_valid = 1; redirect_pc = 32'h1C00_0002; tick();
    redirect_valid = 0; if1_ready = 0; #1;
    n_cmp++; if (req_valid !== 1'b0) begin n_err++; $display("FAIL mis_noreq: got %b want 0", req_valid); end
    tick();
    n_cmp++; if (if0_valid !== 1'b1 || if0_if1_bus[55:36] !== {1'b1, 6'h08, 9'h0, 4'b0001} || if0_if1_bus[31:0] !== 32'h1C00_0002) begin n_err++; $display("FAIL mis_blk: got %b/%h want 1/%h", if0_valid, if0_if1_bus, {1'b1, 6'h08, 9'h0, 4'b0001, 4'b0, 32'h1C00_0002}); end
    if1_ready = 1; tick();
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if ({if0_valid, req_valid} !== 2'b00) begin n_err++; $display("FAIL halt_%0d: got v=%b req=%b want 0/0", k, if0_valid, req_valid); end
      tick();
    end
  endtask

  task automatic test_redirect_resp();
    redirect_valid = 1; redirect_pc = 32'h1C00_0200; #1;
    n_cmp++; if ({flush_IF, icache_cancel} !== 2'b10) begin n_err++; $display("FAIL halt_rd: got flush=%b cancel=%b want 1/0", flush_IF, icache_cancel); end
    tick();
    redirect_valid = 0; #1;
    n_cmp++; if ({req_valid, req_addr} !== {1'b1, 32'h1C00_0200}) begin n_err++; $display("FAIL halt_rd_req: got %b/%h want 1/1c000200", req_valid, req_addr); end
    tick();
    redirect_valid = 1; redirect_pc = 32'h1C00_0300; #1;
    n_cmp++; if ({flush_IF, icache_cancel, if0_valid, req_valid} !== 4'b1100) begin n_err++; $display("FAIL resp_rd: got %b want 1100", {flush_IF, icache_cancel, if0_valid, req_valid}); end
    tick();
    redirect_valid = 0; addr_ok = 0; #1;
    n_cmp++; if ({req_valid, req_addr, flush_IF, icache_cancel} !== {1'b1, 32'h1C00_0300, 2'b00}) begin n_err++; $display("FAIL resp_rd_after: got %b/%h/%b%b want 1/1c000300/00", req_valid, req_addr, flush_IF, icache_cancel); end
    redirect_valid = 1; redirect_pc = 32'h1C00_0400; addr_ok = 1; #1;
    n_cmp++; if ({req_valid, icache_cancel} !== 2'b00) begin n_err++; $display("FAIL rd_aok: got req=%b cancel=%b want 0/0", req_valid, icache_cancel); end
    tick();
    redirect_valid = 0; addr_ok = 0; #1;
    n_cmp++; if ({if0_valid, req_valid, req_addr} !== {2'b01, 32'h1C00_0400}) begin n_err++; $display("FAIL rd_aok_after: got %b/%b/%h want 0/1/1c000400", if0_valid, req_valid, req_addr); end
  endtask

  task automatic test_stall_wrap();
    fetch_stall = 1; addr_ok = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if ({req_valid, if0_valid} !== 2'b00) begin n_err++; $display("FAIL stall_%0d: got req=%b v=%b want 0/0", k, req_valid, if0_valid); end
      tick();
    end
    fetch_stall = 0; #1;
    n_cmp++; if ({req_valid, req_addr} !== {1'b1, 32'h1C00_0400}) begin n_err++; $display("FAIL stall_resume: got %b/%h want 1/1c000400", req_valid, req_addr); end
    tick(); if1_ready = 1; tick();
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFF0; addr_ok = 0; tick();
    redirect_valid = 0; addr_ok = 1; #1;
    n_cmp++; if ({req_valid, req_addr} !== {1'b1, 32'hFFFF_FFF0}) begin n_err++; $display("FAIL wrap_req: got %b/%h want 1/fffffff0", req_valid, req_addr); end
    tick();
    n_cmp++; if (if0_if1_bus[39:36] !== 4'b1111 || if0_if1_bus[31:0] !== 32'hFFFF_FFF0) begin n_err++; $display("FAIL wrap_blk: got %b/%h want 1111/fffffff0", if0_if1_bus[39:36], if0_if1_bus[31:0]); end
    addr_ok = 0; tick();
    n_cmp++; if ({req_valid, req_addr} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL wrap_next: got %b/%h want 1/00000000", req_valid, req_addr); end
  endtask

  task automatic test_reset_resp();
    addr_ok = 1; tick();
    rst = 1; redirect_valid = 1; redirect_pc = 32'h1C00_0800; #1;
    n_cmp++; if ({if0_valid, icache_cancel, flush_IF} !== 3'b000) begin n_err++; $display("FAIL rst_resp: got %b want 000", {if0_valid, icache_cancel, flush_IF}); end
    tick();
    rst = 0; redirect_valid = 0; addr_ok = 0; #1;
    n_cmp++; if (if0_if1_bus !== 56'h0 || req_addr !== 32'h1C00_0000 || if0_valid !== 1'b0) begin n_err++; $display("FAIL rst_resp_after: got bus=%h addr=%h v=%b want 0/1c000000/0", if0_if1_bus, req_addr, if0_valid); end
  endtask

  task automatic test_random();
    logic e_req, e_if0, e_flush, e_cancel;
    for (int k = 0; k < 600; k++) begin
      rst = ($urandom_range(0, 149) == 0);
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFC0 | ($urandom & 32'h3C)) : ($urandom & ~32'h3);
      if ($urandom_range(0, 5) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
      fetch_stall = ($urandom_range(0, 4) == 0);
      addr_ok = $urandom_range(0, 1) == 1;
      if1_ready = $urandom_range(0, 2) != 0;
      #1;
      e_req = !rst && !redirect_valid && !m_busy && !m_halt && m_pc[1:0] == 2'b00 && !fetch_stall;
      e_if0 = !rst && !redirect_valid && m_busy;
      e_flush = !rst && redirect_valid;
      e_cancel = !rst && redirect_valid && m_busy;
      n_cmp++; if (req_valid !== e_req) begin n_err++; $display("FAIL rnd_req_valid@%0d: got %b want %b", k, req_valid, e_req); end
      n_cmp++; if (req_addr !== (m_pc & ~32'hF)) begin n_err++; $display("FAIL rnd_req_addr@%0d: got %h want %h", k, req_addr, m_pc & ~32'hF); end
      n_cmp++; if (if0_valid !== e_if0) begin n_err++; $display("FAIL rnd_if0_valid@%0d: got %b want %b", k, if0_valid, e_if0); end
      n_cmp++; if ({flush_IF, icache_cancel} !== {e_flush, e_cancel}) begin n_err++; $display("FAIL rnd_flush_cancel@%0d: got %b%b want %b%b", k, flush_IF, icache_cancel, e_flush, e_cancel); end
      if (e_if0) begin
        n_cmp++; if (if0_if1_bus !== m_bus) begin n_err++; $display("FAIL rnd_bus@%0d: got %h want %h", k, if0_if1_bus, m_bus); end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_redirect_partial();
    test_hold();
    test_misaligned();
    test_redirect_resp();
    test_stall_wrap();
    test_reset_resp();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
